i2c_cmd_sequencer: RTL and testbench

Command sequencer sitting directly upstream of the `I2C_Protocol` master. It accepts queued single-byte I2C transactions over a valid/ready interface and drives them one at a time into the master's `enable`/`addr`/`rw`/`data_in` port, using the master's `ready` as its handshake. For each read transaction it captures the master's `data_out` and returns it on a buffered response stream. It lets software or upstream logic post bursts of register accesses without polling the master.

---
 rtl/i2c_seq_pkg.sv | 27 ++
 rtl/i2c_cmd_sequencer_if.sv | 42 ++++
 rtl/i2c_seq_fifo.sv | 53 +++++
 rtl/i2c_cmd_sequencer.sv | 147 ++++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 393 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_seq_pkg
// Description : FSM encoding, command/response entry layout and timeout fill
//               byte shared by the I2C command sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_t;

  // Command entry {rw, addr[6:0], data[7:0]}; response entry {addr[6:0], data[7:0]}
  localparam int c_CMD_W        = 16;
  localparam int c_CMD_RW_BIT   = 15;
  localparam int c_CMD_ADDR_LSB = 8;
  localparam int c_CMD_DATA_LSB = 0;
  localparam int c_RSP_W        = 15;

  localparam logic [7:0] c_TIMEOUT_FILL = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/i2c_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_cmd_sequencer_if
// Description : Command, response and master-port bundle of the sequencer.
//               slave = sequencer side, master = environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_data;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [6:0] rsp_addr;
  logic [7:0] rsp_data;

  logic       m_enable;
  logic       m_rw;
  logic [6:0] m_addr;
  logic [7:0] m_data_in;
  logic       m_ready;
  logic [7:0] m_data_out;

  logic       busy;
  logic       timeout_err;

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_data, rsp_ready, m_ready, m_data_out,
    output cmd_ready, rsp_valid, rsp_addr, rsp_data,
           m_enable, m_rw, m_addr, m_data_in, busy, timeout_err
  );

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_data, rsp_ready, m_ready, m_data_out,
    input  cmd_ready, rsp_valid, rsp_addr, rsp_data,
           m_enable, m_rw, m_addr, m_data_in, busy, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/i2c_seq_fifo.sv
`default_nettype none
// ============================================================================
// Module      : i2c_seq_fifo
// Description : Synchronous FIFO, power-of-two depth, registered count.
//               Push into a full FIFO is honoured when a pop occurs together.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_seq_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  wire              clk,
  input  wire              rst,
  input  wire              i_push,
  input  wire  [WIDTH-1:0] i_data,
  input  wire              i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (c_AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage is cleared on reset so the head reads zero out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{c_AW{1'b0}}, w_do_push} - {{c_AW{1'b0}}, w_do_pop};
    end
  end
endmodule
`default_nettype wire

// File: rtl/i2c_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : i2c_cmd_sequencer
// Description : Queues single-byte I2C transactions and feeds them one at a
//               time to the I2C master; read bytes return on a response FIFO.
//               Optional per-transaction timeout: define I2C_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
import i2c_seq_pkg::*;

module i2c_cmd_sequencer #(
  parameter int CMD_DEPTH      = 4,
  parameter int RSP_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input wire                  clk,
  input wire                  rst,
  i2c_cmd_sequencer_if.slave  bus
);
  seq_state_t           r_state;
  logic                 r_m_enable;
  logic                 r_m_rw;
  logic [6:0]           r_m_addr;
  logic [7:0]           r_m_data_in;

  logic [c_CMD_W-1:0]   w_cmd_head;
  logic                 w_cmd_full;
  logic                 w_cmd_empty;
  logic                 w_cmd_push;
  logic [c_RSP_W-1:0]   w_rsp_head;
  logic                 w_rsp_full;
  logic                 w_rsp_empty;
  logic                 w_rsp_push;
  logic [7:0]           w_rsp_byte;
  logic                 w_launch;
  logic                 w_tmo_expire;

  assign w_cmd_push = bus.cmd_valid && !w_cmd_full;
  // Reads only launch when their response is guaranteed a slot
  assign w_launch   = (r_state == ST_IDLE) && !w_cmd_empty && bus.m_ready &&
                      (!w_cmd_head[c_CMD_RW_BIT] || !w_rsp_full);
  assign w_rsp_push = (r_state == ST_DONE) && r_m_rw;

  i2c_seq_fifo #(.WIDTH(c_CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_cmd_push),
    .i_data  ({bus.cmd_rw, bus.cmd_addr, bus.cmd_data}),
    .i_pop   (w_launch),
    .o_data  (w_cmd_head),
    .o_full  (w_cmd_full),
    .o_empty (w_cmd_empty)
  );

  i2c_seq_fifo #(.WIDTH(c_RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_rsp_push),
    .i_data  ({r_m_addr, w_rsp_byte}),
    .i_pop   (bus.rsp_ready),
    .o_data  (w_rsp_head),
    .o_full  (w_rsp_full),
    .o_empty (w_rsp_empty)
  );

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [c_TMO_W-1:0] r_tmo_cnt;
  logic               r_tmo_hit;
  logic               r_timeout_err;

  assign w_tmo_expire = ((r_state == ST_LAUNCH) || (r_state == ST_BUSY)) &&
                        (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo_cnt     <= '0;
      r_tmo_hit     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else if (w_launch) begin
      r_tmo_cnt <= '0;
      r_tmo_hit <= 1'b0;
    end else if (w_tmo_expire) begin
      r_tmo_hit     <= 1'b1;
      r_timeout_err <= 1'b1;
    end else if ((r_state == ST_LAUNCH) || (r_state == ST_BUSY)) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  assign w_rsp_byte      = r_tmo_hit ? c_TIMEOUT_FILL : bus.m_data_out;
  assign bus.timeout_err = r_timeout_err;
`else
  assign w_tmo_expire    = 1'b0;
  assign w_rsp_byte      = bus.m_data_out;
  assign bus.timeout_err = 1'b0;
`endif

  // Dropping enable right after ready falls steers the master to STOP
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_m_enable  <= 1'b0;
      r_m_rw      <= 1'b0;
      r_m_addr    <= '0;
      r_m_data_in <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_m_rw      <= w_cmd_head[c_CMD_RW_BIT];
            r_m_addr    <= w_cmd_head[c_CMD_ADDR_LSB +: 7];
            r_m_data_in <= w_cmd_head[c_CMD_DATA_LSB +: 8];
            r_m_enable  <= 1'b1;
            r_state     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          if (w_tmo_expire) begin
            r_m_enable <= 1'b0;
            r_state    <= ST_DONE;
          end else if (!bus.m_ready) begin
            r_m_enable <= 1'b0;
            r_state    <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_tmo_expire || bus.m_ready) r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = !w_cmd_full;
  assign bus.rsp_valid = !w_rsp_empty;
  assign bus.rsp_addr  = w_rsp_head[14:8];
  assign bus.rsp_data  = w_rsp_head[7:0];
  assign bus.m_enable  = r_m_enable;
  assign bus.m_rw      = r_m_rw;
  assign bus.m_addr    = r_m_addr;
  assign bus.m_data_in = r_m_data_in;
  assign bus.busy      = (r_state != ST_IDLE) || !w_cmd_empty;
endmodule
`default_nettype wire

// File: tb/tb_i2c_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_cmd_sequencer
// Description : Self-checking bench: behavioural I2C master/slave, in-order
//               command and response reference queues, scenario tasks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_cmd_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_cmd_sequencer_if ifc ();

  i2c_cmd_sequencer #(
    .CMD_DEPTH      (4),
    .RSP_DEPTH      (2),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct {
    logic       rw;
    logic [6:0] addr;
    logic [7:0] data;
  } cmd_t;

  int          checks   = 0;
  int          failures = 0;
  cmd_t        exp_cmd[$];
  logic [14:0] exp_rsp[$];
  logic [7:0]  slave_mem [128];
  logic [7:0]  ref_mem   [128];
  logic        hold_idle  = 1'b0;
  logic        stall_busy = 1'b0;
  logic        rsp_en     = 1'b0;
  int          n_launch   = 0;
  int          mdl_ph     = 0;

  // Master + slave model: ready drops 0..2 cycles after enable is seen,
  // transfer lasts 2..6 cycles, writes update slave memory.
  initial begin : master_model
    int   cnt;
    bit   first;
    cmd_t cur;
    cmd_t e;
    cnt = 0; first = 0;
    ifc.m_ready = 1'b1;
    ifc.m_data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        mdl_ph = 0;
        ifc.m_ready = 1'b1;
      end else if (mdl_ph == 0) begin
        if (ifc.m_enable) begin
          cur.rw = ifc.m_rw; cur.addr = ifc.m_addr; cur.data = ifc.m_data_in;
          n_launch++;
          checks++;
          if (exp_cmd.size() == 0) begin
            failures++;
            $display("FAIL launch_unexpected got rw=%b addr=%h data=%h required none", cur.rw, cur.addr, cur.data);
          end else begin
            e = exp_cmd.pop_front();
            if (e.rw !== cur.rw || e.addr !== cur.addr || (!e.rw && e.data !== cur.data)) begin
              failures++;
              $display("FAIL launch_order got rw=%b addr=%h data=%h required rw=%b addr=%h data=%h",
                       cur.rw, cur.addr, cur.data, e.rw, e.addr, e.data);
            end
          end
          cnt = $urandom_range(0, 2);
          if (cnt == 0) begin
            ifc.m_ready = 1'b0; mdl_ph = 2; first = 1; cnt = $urandom_range(2, 6);
          end else begin
            mdl_ph = 1;
          end
        end else begin
          ifc.m_ready = !hold_idle;
        end
      end else if (mdl_ph == 1) begin
        checks++;
        if (ifc.m_enable !== 1'b1 || ifc.m_addr !== cur.addr || ifc.m_rw !== cur.rw) begin
          failures++;
          $display("FAIL enable_hold got en=%b addr=%h rw=%b required en=1 addr=%h rw=%b",
                   ifc.m_enable, ifc.m_addr, ifc.m_rw, cur.addr, cur.rw);
        end
        cnt--;
        if (cnt == 0) begin
          ifc.m_ready = 1'b0; mdl_ph = 2; first = 1; cnt = $urandom_range(2, 6);
        end
      end else begin
        if (first) begin
          checks++;
          if (ifc.m_enable !== 1'b0) begin
            failures++;
            $display("FAIL enable_drop got en=%b required 0 one cycle after ready fell", ifc.m_enable);
          end
          first = 0;
        end
        checks++;
        if (ifc.m_addr !== cur.addr || ifc.m_rw !== cur.rw || (!cur.rw && ifc.m_data_in !== cur.data)) begin
          failures++;
          $display("FAIL port_stable got addr=%h rw=%b data=%h required addr=%h rw=%b data=%h",
                   ifc.m_addr, ifc.m_rw, ifc.m_data_in, cur.addr, cur.rw, cur.data);
        end
        if (!stall_busy) begin
          cnt--;
          if (cnt == 0) begin
            if (!cur.rw) slave_mem[cur.addr] = cur.data;
            ifc.m_data_out = cur.rw ? slave_mem[cur.addr] : 8'($urandom);
            ifc.m_ready = 1'b1;
            mdl_ph = 0;
          end
        end
      end
    end
  end

  initial begin : consumer
    logic [14:0] e;
    ifc.rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      ifc.rsp_ready = rsp_en && ($urandom_range(0, 3) != 0);
      if (!rst && ifc.rsp_valid && ifc.rsp_ready) begin
        checks++;
        if (exp_rsp.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected got addr=%h data=%h required none", ifc.rsp_addr, ifc.rsp_data);
        end else begin
          e = exp_rsp.pop_front();
          if ({ifc.rsp_addr, ifc.rsp_data} !== e) begin
            failures++;
            $display("FAIL rsp_value got addr=%h data=%h required addr=%h data=%h",
                     ifc.rsp_addr, ifc.rsp_data, e[14:8], e[7:0]);
          end
        end
      end
    end
  end

  task automatic send_cmd(input logic rw, input logic [6:0] addr, input logic [7:0] data, input bit tmo);
    int   n;
    cmd_t c;
    @(negedge clk);
    ifc.cmd_valid = 1'b1; ifc.cmd_rw = rw; ifc.cmd_addr = addr; ifc.cmd_data = data;
    n = 0;
    while (ifc.cmd_ready !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) begin
      checks++; failures++;
      $display("FAIL cmd_accept got cmd_ready=%b required 1 within 3000 cycles", ifc.cmd_ready);
    end else begin
      c.rw = rw; c.addr = addr; c.data = data;
      exp_cmd.push_back(c);
      if (rw) exp_rsp.push_back({addr, tmo ? 8'hFF : ref_mem[addr]});
      else    ref_mem[addr] = data;
    end
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin @(posedge clk); #1; n++; end
    while ((ifc.busy || mdl_ph != 0 || !ifc.m_ready) && n < 5000);
    if (n >= 5000) begin
      checks++; failures++;
      $display("FAIL %s_idle got busy=%b required 0 within 5000 cycles", tag, ifc.busy);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    rsp_en = 1'b1;
    while ((exp_rsp.size() != 0 || ifc.rsp_valid) && n < 5000) begin @(posedge clk); #1; n++; end
    checks++;
    if (exp_rsp.size() != 0 || ifc.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain got pending=%0d rsp_valid=%b required 0 0", tag, exp_rsp.size(), ifc.rsp_valid);
    end
  endtask

  task automatic check_reset_state(input string tag);
    logic [35:0] got;
    got = {ifc.cmd_ready, ifc.rsp_valid, ifc.rsp_addr, ifc.rsp_data, ifc.m_enable, ifc.m_rw,
           ifc.m_addr, ifc.m_data_in, ifc.busy, ifc.timeout_err};
    checks++;
    if (got !== {1'b1, 35'b0}) begin
      failures++;
      $display("FAIL %s_reset_values got %h required %h", tag, got, {1'b1, 35'b0});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("init");
    rst = 1'b0;
  endtask

  task automatic test_write();
    int l0 = n_launch;
    send_cmd(1'b0, 7'h2A, 8'h5A, 1'b0);
    checks++;
    if (ifc.m_enable !== 1'b0) begin
      failures++; $display("FAIL wr_latency_early got en=%b required 0", ifc.m_enable);
    end
    @(posedge clk); #1;
    checks++;
    if (ifc.m_enable !== 1'b1) begin
      failures++; $display("FAIL wr_latency got en=%b required 1 two cycles after push", ifc.m_enable);
    end
    wait_idle("wr");
    checks++;
    if (ifc.rsp_valid !== 1'b0 || ifc.busy !== 1'b0 || n_launch != l0 + 1 || slave_mem[7'h2A] !== 8'h5A) begin
      failures++;
      $display("FAIL wr_result got rsp_valid=%b busy=%b launches=%0d mem=%h required 0 0 %0d 5a",
               ifc.rsp_valid, ifc.busy, n_launch - l0, slave_mem[7'h2A], 1);
    end
  endtask

  task automatic test_read();
    int n = 0;
    bit seen = 0;
    slave_mem[7'h2A] = 8'hCC; ref_mem[7'h2A] = 8'hCC;
    rsp_en = 1'b0;
    send_cmd(1'b1, 7'h2A, 8'h00, 1'b0);
    while (n < 200) begin
      @(posedge clk); #1; n++;
      if (!ifc.m_ready) seen = 1;
      else if (seen) break;
    end
    checks++;
    if (n >= 200 || ifc.rsp_valid !== 1'b0) begin
      failures++; $display("FAIL rd_early got rsp_valid=%b cycles=%0d required 0", ifc.rsp_valid, n);
    end
    @(posedge clk); #1;
    checks++;
    if (ifc.rsp_valid !== 1'b1 || ifc.rsp_addr !== 7'h2A || ifc.rsp_data !== 8'hCC) begin
      failures++;
      $display("FAIL rd_rsp got v=%b addr=%h data=%h required 1 2a cc", ifc.rsp_valid, ifc.rsp_addr, ifc.rsp_data);
    end
    drain("rd");
    wait_idle("rd");
  endtask

  task automatic test_back_to_back();
    int l0 = n_launch;
    rsp_en = 1'b0;
    hold_idle = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 4; i++)
      send_cmd(logic'(i % 2), 7'($urandom_range(0, 127)), 8'($urandom), 1'b0);
    checks++;
    if (ifc.cmd_ready !== 1'b0 || ifc.busy !== 1'b1) begin
      failures++; $display("FAIL b2b_full got cmd_ready=%b busy=%b required 0 1", ifc.cmd_ready, ifc.busy);
    end
    hold_idle = 1'b0;
    wait_idle("b2b");
    checks++;
    if (n_launch != l0 + 4 || ifc.rsp_valid !== 1'b1 || exp_rsp.size() != 2) begin
      failures++;
      $display("FAIL b2b_done got launches=%0d rsp_valid=%b held=%0d required 4 1 2",
               n_launch - l0, ifc.rsp_valid, exp_rsp.size());
    end
  endtask

  task automatic test_rsp_full();
    int l0 = n_launch;
    send_cmd(1'b1, 7'($urandom_range(0, 127)), 8'h00, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (n_launch != l0 || ifc.m_enable !== 1'b0 || ifc.busy !== 1'b1) begin
      failures++;
      $display("FAIL rspfull_stall got launches=%0d en=%b busy=%b required 0 0 1", n_launch - l0, ifc.m_enable, ifc.busy);
    end
    rsp_en = 1'b1;
    wait_idle("rspfull");
    drain("rspfull");
    checks++;
    if (n_launch != l0 + 1) begin
      failures++; $display("FAIL rspfull_resume got launches=%0d required 1", n_launch - l0);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int l0;
    rsp_en = 1'b0;
    send_cmd(1'b1, 7'h33, 8'h00, 1'b0);
    send_cmd(1'b0, 7'h34, 8'h77, 1'b0);
    while (mdl_ph != 2 && n < 200) begin @(posedge clk); #1; n++; end
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_state("mid");
    rst = 1'b0;
    exp_cmd.delete();
    exp_rsp.delete();
    ref_mem[7'h34] = slave_mem[7'h34];
    l0 = n_launch;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (n_launch != l0 || ifc.busy !== 1'b0 || ifc.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_flush got launches=%0d busy=%b rsp_valid=%b required 0 0 0", n_launch - l0, ifc.busy, ifc.rsp_valid);
    end
  endtask

  task automatic test_random();
    rsp_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_cmd(logic'($urandom_range(0, 1)), 7'($urandom_range(16, 19)), 8'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_idle("rand");
    drain("rand");
    checks++;
    if (exp_cmd.size() != 0) begin
      failures++; $display("FAIL rand_cmds got pending=%0d required 0", exp_cmd.size());
    end
  endtask

`ifdef I2C_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    rsp_en = 1'b1;
    stall_busy = 1'b1;
    send_cmd(1'b1, 7'h41, 8'h00, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (ifc.m_enable !== 1'b1) begin
      failures++; $display("FAIL tmo_launch got en=%b required 1", ifc.m_enable);
    end
    repeat (49) @(posedge clk);
    #1;
    checks++;
    if (ifc.timeout_err !== 1'b0) begin
      failures++; $display("FAIL tmo_early got err=%b required 0 at cycle 49", ifc.timeout_err);
    end
    @(posedge clk); #1;
    checks++;
    if (ifc.timeout_err !== 1'b1 || ifc.m_enable !== 1'b0) begin
      failures++; $display("FAIL tmo_fire got err=%b en=%b required 1 0 at cycle 50", ifc.timeout_err, ifc.m_enable);
    end
    repeat (3) @(posedge clk);
    stall_busy = 1'b0;
    send_cmd(1'b0, 7'h42, 8'h99, 1'b0);
    wait_idle("tmo");
    drain("tmo");
    checks++;
    if (ifc.timeout_err !== 1'b1 || exp_cmd.size() != 0) begin
      failures++; $display("FAIL tmo_sticky got err=%b pending=%0d required 1 0", ifc.timeout_err, exp_cmd.size());
    end
  endtask
`else
  task automatic test_timeout();
    checks++;
    if (ifc.timeout_err !== 1'b0) begin
      failures++; $display("FAIL tmo_tied got err=%b required 0", ifc.timeout_err);
    end
  endtask
`endif

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    ifc.cmd_valid = 1'b0; ifc.cmd_rw = 1'b0; ifc.cmd_addr = 7'h00; ifc.cmd_data = 8'h00;
    for (int i = 0; i < 128; i++) begin
      slave_mem[i] = 8'($urandom);
      ref_mem[i]   = slave_mem[i];
    end
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_rsp_full();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
